// File: rtl/stack_pkg.sv
// ----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the arbitrated stack: FSM state encoding and the
// default data width / stack depth used by the interface, storage and top.
// ----------------------------------------------------------------------------
package stack_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage : stack_pkg

// File: rtl/stack_arb_if.sv
// ----------------------------------------------------------------------------
// stack_arb_if
// Request/response bundle between two requesters and the arbitrated stack.
//   wr0/wr1, rd0/rd1 : push / pop requests, held until the matching ack
//   i0/i1            : push data, stable while the request is held
//   ack0/ack1        : one-cycle completion pulses
//   err0/err1        : valid with ack, 1 = push on full or pop on empty
//   o0/o1            : pop data, valid with ack, held otherwise
//   full/empty/cnt   : stack occupancy status
// master = requester side, slave = stack side.
// ----------------------------------------------------------------------------
interface stack_arb_if #(
    parameter int WIDTH = stack_pkg::DEF_WIDTH,
    parameter int DEPTH = stack_pkg::DEF_DEPTH
);

    logic                     wr0;
    logic                     wr1;
    logic                     rd0;
    logic                     rd1;
    logic [WIDTH-1:0]         i0;
    logic [WIDTH-1:0]         i1;
    logic                     ack0;
    logic                     ack1;
    logic                     err0;
    logic                     err1;
    logic [WIDTH-1:0]         o0;
    logic [WIDTH-1:0]         o1;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   cnt;

    modport master (
        output wr0, wr1, rd0, rd1, i0, i1,
        input  ack0, ack1, err0, err1, o0, o1, full, empty, cnt
    );

    modport slave (
        input  wr0, wr1, rd0, rd1, i0, i1,
        output ack0, ack1, err0, err1, o0, o1, full, empty, cnt
    );

endinterface : stack_arb_if

// File: rtl/stack_mem.sv
// ----------------------------------------------------------------------------
// stack_mem
// LIFO storage plus stack pointer. The pointer equals the occupancy; push
// writes at index ptr, pop exposes the entry at index ptr-1 on o_data.
//   i_clk, i_rst     : clock, synchronous active-high reset (pointer only)
//   i_push, i_pop    : one-cycle strobes; push wins if both are set,
//                      push on full / pop on empty are ignored
//   i_data           : push data
//   o_data           : current top of stack (combinational read)
//   o_full, o_empty  : ptr == DEPTH / ptr == 0
//   o_cnt            : current occupancy
// ----------------------------------------------------------------------------
module stack_mem
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_cnt
);

    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_ptr == FULL_CNT);
    assign o_empty   = (r_ptr == '0);
    assign o_cnt     = r_ptr;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !i_push && !o_empty;

    // Top-of-stack read; the index is meaningless when empty but is never
    // consumed in that case.
    assign o_data = r_mem[AW'(r_ptr - 1'b1)];

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_do_push) begin
            r_ptr <= r_ptr + 1'b1;
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; entries above the pointer are
    // never read, so clearing them would only cost a reset tree.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[AW'(r_ptr)] <= i_data;
        end
    end

endmodule : stack_mem

// File: rtl/stack_arb.sv
// ----------------------------------------------------------------------------
// stack_arb
// Two requesters share one LIFO. A round-robin arbiter picks one request in
// IDLE and latches its operation and data; OP performs the single push or
// pop; ACK registers the winner's ack/err/o for one cycle.
//   c    : clock
//   r    : synchronous active-high reset
//   bus  : stack_arb_if.slave (requests in, responses and status out)
// ----------------------------------------------------------------------------
module stack_arb
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic        c,
    input  logic        r,
    stack_arb_if.slave  bus
);

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_last;      // requester granted most recently
    logic                   r_win;       // latched winner
    logic                   r_is_push;   // latched operation, 1 = push
    logic [WIDTH-1:0]       r_data;      // latched push data
    logic                   r_res_err;   // outcome captured at the OP edge
    logic [WIDTH-1:0]       r_res_data;  // popped value captured at the OP edge

    logic                   r_ack0;
    logic                   r_ack1;
    logic                   r_err0;
    logic                   r_err1;
    logic [WIDTH-1:0]       r_o0;
    logic [WIDTH-1:0]       r_o1;

    logic                   w_req0;
    logic                   w_req1;
    logic                   w_grant;
    logic                   w_win;
    logic                   w_push;
    logic                   w_pop;
    logic [WIDTH-1:0]       w_mem_dout;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_cnt;

    assign w_req0 = bus.wr0 || bus.rd0;
    assign w_req1 = bus.wr1 || bus.rd1;

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (c),
        .i_rst   (r),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_data),
        .o_data  (w_mem_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (w_cnt)
    );

    always_ff @(posedge c) begin
        if (r) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_win   = r_win;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req0 || w_req1) begin
                    w_grant = 1'b1;
                    // Under contention the requester not granted last wins.
                    w_win   = (w_req0 && w_req1) ? ~r_last : w_req1;
                    w_next  = OP;
                end
            end
            OP: begin
                w_push = r_is_push;
                w_pop  = !r_is_push;
                w_next = ACK;
            end
            ACK: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge c) begin
        if (r) begin
            r_last     <= 1'b1;     // requester 0 wins the first contention
            r_win      <= 1'b0;
            r_is_push  <= 1'b0;
            r_data     <= '0;
            r_res_err  <= 1'b0;
            r_res_data <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_o0       <= '0;
            r_o1       <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;

            if (w_grant) begin
                r_last    <= w_win;
                r_win     <= w_win;
                // Push takes priority when wr and rd are both held.
                r_is_push <= w_win ? bus.wr1 : bus.wr0;
                r_data    <= w_win ? bus.i1 : bus.i0;
            end

            if (r_state == OP) begin
                r_res_err  <= r_is_push ? w_full : w_empty;
                r_res_data <= w_mem_dout;
            end

            if (r_state == ACK) begin
                if (!r_win) begin
                    r_ack0 <= 1'b1;
                    r_err0 <= r_res_err;
                    if (!r_is_push && !r_res_err) begin
                        r_o0 <= r_res_data;
                    end
                end else begin
                    r_ack1 <= 1'b1;
                    r_err1 <= r_res_err;
                    if (!r_is_push && !r_res_err) begin
                        r_o1 <= r_res_data;
                    end
                end
            end
        end
    end

    assign bus.ack0  = r_ack0;
    assign bus.ack1  = r_ack1;
    assign bus.err0  = r_err0;
    assign bus.err1  = r_err1;
    assign bus.o0    = r_o0;
    assign bus.o1    = r_o1;
    assign bus.full  = w_full;
    assign bus.empty = w_empty;
    assign bus.cnt   = w_cnt;

endmodule : stack_arb

// File: tb/tb_stack_arb.sv
// ----------------------------------------------------------------------------
// tb_stack_arb
// Directed bench for stack_arb (WIDTH = 8, DEPTH = 8). Requests are driven on
// the falling edge, responses sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_stack_arb;

    logic c;
    logic r;
    int   n_cmp = 0;
    int   n_bad = 0;

    stack_arb_if #(.WIDTH(8), .DEPTH(8)) bus ();

    stack_arb #(.WIDTH(8), .DEPTH(8)) dut (
        .c   (c),
        .r   (r),
        .bus (bus)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge c);
        r = 1'b1;
        @(posedge c);
        @(negedge c);
        r = 1'b0;
    endtask

    // Drive the enabled requesters, wait (bounded) for each one's ack and
    // capture its err/o at that moment; each request drops on its own ack.
    task automatic run(input bit en0, input logic w0, input logic p0, input logic [7:0] d0,
                       input bit en1, input logic w1, input logic p1, input logic [7:0] d1,
                       output int a0, output int a1,
                       output logic e0, output logic e1,
                       output logic [7:0] q0, output logic [7:0] q1);
        @(negedge c);
        if (en0) begin bus.wr0 = w0; bus.rd0 = p0; bus.i0 = d0; end
        if (en1) begin bus.wr1 = w1; bus.rd1 = p1; bus.i1 = d1; end
        a0 = 0; a1 = 0; e0 = 1'b0; e1 = 1'b0; q0 = '0; q1 = '0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge c); #1;
            if (en0 && a0 == 0 && bus.ack0) begin
                a0 = n; e0 = bus.err0; q0 = bus.o0; bus.wr0 = 1'b0; bus.rd0 = 1'b0;
            end
            if (en1 && a1 == 0 && bus.ack1) begin
                a1 = n; e1 = bus.err1; q1 = bus.o1; bus.wr1 = 1'b0; bus.rd1 = 1'b0;
            end
            if ((!en0 || a0 != 0) && (!en1 || a1 != 0)) break;
        end
        bus.wr0 = 1'b0; bus.rd0 = 1'b0; bus.wr1 = 1'b0; bus.rd1 = 1'b0;
    endtask

    task automatic single(input int who, input logic w, input logic p, input logic [7:0] d,
                          input logic exp_err, input logic [7:0] exp_o, input string tag);
        int a0, a1, a;
        logic e0, e1, e;
        logic [7:0] q0, q1, q;
        if (who == 0) run(1, w, p, d, 0, 0, 0, 0, a0, a1, e0, e1, q0, q1);
        else          run(0, 0, 0, 0, 1, w, p, d, a0, a1, e0, e1, q0, q1);
        a = (who == 0) ? a0 : a1;
        e = (who == 0) ? e0 : e1;
        q = (who == 0) ? q0 : q1;
        check({tag, " latency"}, a, 3);
        check({tag, " err"}, e, exp_err);
        check({tag, " o"}, q, exp_o);
        @(posedge c); #1;
        check({tag, " ack pulse"}, (who == 0) ? bus.ack0 : bus.ack1, 1'b0);
    endtask

    initial begin
        int a0, a1, acks;
        logic e0, e1;
        logic [7:0] q0, q1;

        r = 1'b1;
        bus.wr0 = 1'b0; bus.rd0 = 1'b0; bus.i0 = '0;
        bus.wr1 = 1'b0; bus.rd1 = 1'b0; bus.i1 = '0;
        repeat (2) @(posedge c);
        @(negedge c);
        r = 1'b0;

        // Reset state
        check("rst ack0", bus.ack0, 0);
        check("rst ack1", bus.ack1, 0);
        check("rst err0", bus.err0, 0);
        check("rst o0", bus.o0, 0);
        check("rst o1", bus.o1, 0);
        check("rst empty", bus.empty, 1);
        check("rst full", bus.full, 0);
        check("rst cnt", bus.cnt, 0);

        // Single push, latency 3
        single(0, 1, 0, 8'h77, 0, 8'h00, "push0 77");
        check("push0 77 cnt", bus.cnt, 1);
        check("push0 77 empty", bus.empty, 0);

        // LIFO order across requesters
        single(1, 1, 0, 8'h22, 0, 8'h00, "push1 22");
        check("push1 22 cnt", bus.cnt, 2);
        single(0, 0, 1, 8'h00, 0, 8'h22, "pop0");
        check("pop0 cnt", bus.cnt, 1);
        single(1, 0, 1, 8'h00, 0, 8'h77, "pop1");
        check("pop1 empty", bus.empty, 1);
        check("pop1 o0 held", bus.o0, 8'h22);

        // Contention after reset: requester 0 first, then 1
        do_reset();
        check("rst2 o0", bus.o0, 0);
        run(1, 1, 0, 8'hA0, 1, 1, 0, 8'hB1, a0, a1, e0, e1, q0, q1);
        check("dual push a0", a0, 3);
        check("dual push a1", a1, 6);
        check("dual push err0", e0, 0);
        check("dual push err1", e1, 0);
        check("dual push cnt", bus.cnt, 2);
        // Last grant was 1, so 0 wins again
        run(1, 0, 1, 8'h00, 1, 0, 1, 8'h00, a0, a1, e0, e1, q0, q1);
        check("dual pop a0", a0, 3);
        check("dual pop a1", a1, 6);
        check("dual pop o0", q0, 8'hB1);
        check("dual pop o1", q1, 8'hA0);
        // After a lone grant to 0, contention goes to 1
        single(0, 1, 0, 8'h33, 0, 8'hB1, "push0 33");
        run(1, 0, 1, 8'h00, 1, 0, 1, 8'h00, a0, a1, e0, e1, q0, q1);
        check("rr pop a1", a1, 3);
        check("rr pop o1", q1, 8'h33);
        check("rr pop a0", a0, 6);
        check("rr pop empty err0", e0, 1);
        check("rr pop empty o0", q0, 8'hB1);

        // Fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            single(0, 1, 0, 8'h10 + 8'(i), 0, 8'hB1, "fill push");
            check("fill cnt", bus.cnt, i + 1);
        end
        check("fill full", bus.full, 1);
        single(1, 1, 0, 8'hFF, 1, 8'h33, "push full");
        check("push full cnt", bus.cnt, 8);
        check("push full full", bus.full, 1);
        for (int i = 7; i >= 0; i--) begin
            single(0, 0, 1, 8'h00, 0, 8'h10 + 8'(i), "drain pop");
            check("drain cnt", bus.cnt, i);
        end
        check("drain empty", bus.empty, 1);
        single(1, 0, 1, 8'h00, 1, 8'h33, "pop empty");
        check("pop empty cnt", bus.cnt, 0);

        // wr and rd together: push wins
        single(0, 1, 1, 8'h5C, 0, 8'h10, "wr+rd");
        check("wr+rd cnt", bus.cnt, 1);

        // Reset while in OP
        @(negedge c);
        bus.wr0 = 1'b1; bus.i0 = 8'h77;
        @(posedge c);
        @(negedge c);
        r = 1'b1; bus.wr0 = 1'b0;
        @(posedge c); #1;
        check("midrst cnt", bus.cnt, 0);
        check("midrst empty", bus.empty, 1);
        check("midrst ack0", bus.ack0, 0);
        check("midrst o0", bus.o0, 0);
        check("midrst o1", bus.o1, 0);
        @(negedge c);
        r = 1'b0;
        acks = 0;
        repeat (4) begin
            @(posedge c); #1;
            if (bus.ack0 || bus.ack1) acks++;
        end
        check("midrst no ack", acks, 0);
        single(0, 1, 0, 8'h11, 0, 8'h00, "post rst push");
        check("post rst cnt", bus.cnt, 1);
        single(0, 0, 1, 8'h00, 0, 8'h11, "post rst pop");
        check("post rst empty", bus.empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_stack_arb

// File: doc/stack_arb.md
STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, stack entries.
REQ-003 The block SHALL use one clock and one synchronous, active-high reset; no other clock or reset.
REQ-004 c  input  1  clock, all state updates on rising edge.
REQ-005 r  input  1  synchronous active-high reset.
REQ-006 wr0, wr1  input  1 each  push request from requester 0 / 1, held until that requester's ack.
REQ-007 rd0, rd1  input  1 each  pop request from requester 0 / 1, held until that requester's ack.
REQ-008 i0, i1  input  WIDTH each  push data, stable while the request is held.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse, registered.
REQ-010 err0, err1  output  1 each  valid with ack; 1 = rejected (push on full or pop on empty).
REQ-011 o0, o1  output  WIDTH each  pop data, registered, valid with ack.
REQ-012 full, empty  output  1 each  stack count == DEPTH / count == 0.
REQ-013 cnt  output  $clog2(DEPTH)+1  current stack occupancy.

Function
REQ-014 The FSM SHALL have states IDLE, OP and ACK.
REQ-015 IDLE: if any request is active at the edge, the FSM SHALL latch the winner, its operation and its push data, then go to OP; otherwise it stays in IDLE.
REQ-016 OP: the FSM SHALL perform exactly one push or pop on the stack, then go to ACK.
REQ-017 ACK: the FSM SHALL set the winner's ack (plus err and o) for one cycle, then go to IDLE.
REQ-018 Latency: a request sampled at edge k SHALL produce ack high in the cycle after edge k+2; the next grant is no earlier than edge k+3.
REQ-019 Arbitration SHALL be round-robin.
- Only one requester active: that requester is granted.
- Both active: the requester not granted last is granted.
- The last-grant pointer updates only on a grant.
REQ-020 When a requester asserts wr and rd together, push SHALL take priority over pop.
REQ-021 Push with count < DEPTH SHALL write the latched data at index count and increment count; err = 0.
REQ-022 Pop with count > 0 SHALL return the entry at index count-1 on o of the winner and decrement count; err = 0.
REQ-023 Push when full, or pop when empty, SHALL leave the stack, count and o unchanged, and SHALL ack with err = 1.
REQ-024 The non-winning requester's ack, err and o SHALL be unaffected by the winner's operation.
REQ-025 A request withdrawn before it is granted SHALL be ignored; request changes after a grant SHALL NOT affect the latched operation.
REQ-026 full, empty and cnt SHALL be combinational from the stack pointer; they update the cycle after the OP edge.

Reset
REQ-027 With r = 1 at an edge, the block SHALL do the following, in any state, including mid-operation:
- FSM goes to IDLE.
- Stack pointer goes to 0, so empty = 1, full = 0, cnt = 0.
- ack0/1 and err0/1 go to 0.
- o0/1 go to 0.
- Last-grant pointer is set so that requester 0 wins the first contention.
REQ-028 An operation interrupted by reset SHALL be abandoned without ack; stack contents need not be cleared.

Structure
REQ-029 A shared package stack_pkg SHALL hold the FSM state enum and the default WIDTH/DEPTH constants.
REQ-030 The storage and pointer SHALL be one sub-module, stack_mem, with:
- push and pop strobes, data in, data out;
- full, empty and cnt outputs.
stack_arb SHALL contain the FSM, the arbiter and the output registers.

Verification
REQ-031 Reset, then req0 push 8'h77 -> ack0 exactly 3 cycles later, err0 = 0, cnt = 1, empty = 0.
REQ-032 Req0 pushes 8'h77, then req1 pushes 8'h22, then req0 pops -> o0 = 8'h22, err0 = 0, cnt = 1; then req1 pops -> o1 = 8'h77, empty = 1.
REQ-033 wr0 and wr1 asserted together after reset with i0 = 8'hA0, i1 = 8'hB1 -> req0 acked first, req1 acked 3 cycles later; pops return 8'hB1 then 8'hA0; round-robin alternates under sustained contention.
REQ-034 Eight pushes until full = 1, then a ninth push of 8'hFF -> err = 1, cnt = 8, top entry unchanged; pop on empty -> err = 1, o unchanged, cnt = 0.
REQ-035 wr0 = rd0 = 1 together with i0 = 8'h5C -> push performed, cnt increments, err0 = 0.
REQ-036 r asserted while the FSM is in OP -> next cycle: IDLE, cnt = 0, no ack, outputs 0; a following push of 8'h11 completes normally.
